// File: rtl/fixed_point.sv
// Shared fixed-point number format for the gfx datapath.
// Signed two's-complement Q8.8 raw value.
package fixed_point;

  typedef logic signed [15:0] fixed_point_t;

endpackage

// File: rtl/fixed_point_accumulator_if.sv
// Operand stream in, packet-sum stream out, for fixed_point_accumulator.
// master drives operands and result-ready; slave is the accumulator.
interface fixed_point_accumulator_if #(
  parameter int COUNT_W = 16
);
  import fixed_point::*;

  logic                in_valid;
  logic                in_ready;
  fixed_point_t        in_data;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  fixed_point_t        out_data;
  logic                out_overflow;
  logic [COUNT_W-1:0]  out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_overflow, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_overflow, out_count
  );

endinterface

// File: rtl/fixed_point_accumulator.sv
// Streaming packet adder: sums fixed_point_t operands per packet, one result per packet.
// Define FIXED_POINT_ACC_SATURATE_EN to clamp overflowing adds instead of wrapping.
module fixed_point_accumulator #(
  parameter int COUNT_W = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  fixed_point_accumulator_if.slave bus
);

  localparam int W = $bits(fixed_point::fixed_point_t);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUTPUT
  } state_t;

  state_t             state, state_nxt;
  logic [W-1:0]       acc, acc_nxt, acc_add, sum, din;
  logic               ovf, ovf_nxt, add_ovf, beat;
  logic [COUNT_W-1:0] cnt, cnt_nxt;

  assign din = bus.in_data;
  assign sum = acc + din;
  // Same operand signs with a differing result sign is the only overflow case.
  assign add_ovf = (acc[W-1] == din[W-1]) && (sum[W-1] != acc[W-1]);

`ifdef FIXED_POINT_ACC_SATURATE_EN
  assign acc_add = add_ovf ? (acc[W-1] ? {1'b1, {(W-1){1'b0}}}
                                       : {1'b0, {(W-1){1'b1}}})
                           : sum;
`else
  assign acc_add = sum;
`endif

  assign bus.in_ready     = (state != OUTPUT);
  assign bus.out_valid    = (state == OUTPUT);
  assign bus.out_data     = fixed_point::fixed_point_t'(acc);
  assign bus.out_overflow = ovf;
  assign bus.out_count    = cnt;

  assign beat = bus.in_valid && (state != OUTPUT);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    ovf_nxt   = ovf;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (beat) begin
          acc_nxt   = din;
          ovf_nxt   = 1'b0;
          cnt_nxt   = COUNT_W'(1);
          state_nxt = bus.in_last ? OUTPUT : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_nxt = acc_add;
          ovf_nxt = ovf | add_ovf;
          cnt_nxt = (&cnt) ? cnt : cnt + 1'b1;
          if (bus.in_last) state_nxt = OUTPUT;
        end
      end
      OUTPUT: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      ovf   <= ovf_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule
